// File: rtl/clk_div_ctrl_if.sv
// Divisor-request port of the clock-divide controller: host offers a divisor
// with valid/ready, controller answers with ready and a one-cycle reject pulse.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 10
);
  // Valid/ready: a request transfers on a rising clock edge where cfg_valid and
  // cfg_ready are both 1; the host holds cfg_valid and cfg_div stable until then.
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time integer clock divider: owns the divide counter and applies start,
// stop and divisor changes only at period boundaries so clk_out never runts.
module clk_div_ctrl #(
  parameter int CNT_W   = 10,
  parameter int DEF_DIV = 7,
  parameter int MIN_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  clk_div_ctrl_if.slave    cfg,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_vld;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_pend_div_nxt;
  logic             w_pend_vld_nxt;
  logic             w_accept;
  logic             w_legal;
  logic             w_load;
  logic             w_boundary;
  logic             w_run_nxt;

  assign w_accept   = cfg.cfg_valid && cfg.cfg_ready;
  assign w_legal    = cfg.cfg_div >= MIN_V;
  assign w_load     = w_accept && w_legal;
  assign w_boundary = (r_state != S_IDLE) && (r_cnt == cur_div - ONE_V);
  assign w_run_nxt  = (w_state_nxt != S_IDLE);
  assign dbg_state  = r_state;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_div_nxt      = cur_div;
    w_pend_div_nxt = r_pend_div;
    w_pend_vld_nxt = r_pend_vld;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_load) w_div_nxt = cfg.cfg_div;
        if (en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!en) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // en coming back before the boundary resumes without touching the phase
        if (en)              w_state_nxt = S_RUN;
        else if (w_boundary) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // While active, divisor changes only land on the wrap edge; a request taken
    // in the boundary cycle itself is applied directly without going pending.
    if (r_state != S_IDLE) begin
      if (w_boundary) begin
        w_cnt_nxt = '0;
        if (w_load)          w_div_nxt = cfg.cfg_div;
        else if (r_pend_vld) w_div_nxt = r_pend_div;
        w_pend_vld_nxt = 1'b0;
      end else begin
        w_cnt_nxt = r_cnt + ONE_V;
        if (w_load) begin
          w_pend_vld_nxt = 1'b1;
          w_pend_div_nxt = cfg.cfg_div;
        end
      end
    end
  end

  // Outputs are computed from next-cycle count/divisor so they line up with cnt.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pend_div    <= DEF_V;
      r_pend_vld    <= 1'b0;
      cur_div       <= DEF_V;
      clk_out       <= 1'b0;
      tick          <= 1'b0;
      busy          <= 1'b0;
      cfg.cfg_ready <= 1'b1;
      cfg.cfg_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pend_div    <= w_pend_div_nxt;
      r_pend_vld    <= w_pend_vld_nxt;
      cur_div       <= w_div_nxt;
      clk_out       <= w_run_nxt && (w_cnt_nxt < (w_div_nxt >> 1));
      tick          <= w_run_nxt && (w_cnt_nxt == w_div_nxt - ONE_V);
      busy          <= w_run_nxt;
      cfg.cfg_ready <= !w_pend_vld_nxt;
      cfg.cfg_err   <= w_accept && !w_legal;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: period-level reference model feeds an expected queue,
// a monitor compares every cycle's registered outputs against it.
module tb_clk_div_ctrl;
  localparam int CNT_W = 10;
  localparam int DEF_DIV = 7;
  localparam int VW = CNT_W + 5;

  logic             clk_in;
  logic             rst_n;
  logic             en;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cur_div;
  logic [1:0]       dbg_state;

  clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .MIN_DIV(2)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .cfg       (cfg_if.slave),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [VW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Divider seen as "active or not", position within the current period,
  // an optional stop request and at most one waiting divisor.
  bit m_on, m_stopping, m_pend_v, m_err;
  int m_pos, m_div, m_pend;

  task automatic model_reset();
    m_on = 0; m_stopping = 0; m_pend_v = 0; m_err = 0;
    m_pos = 0; m_div = DEF_DIV; m_pend = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input int d);
    bit acc, good, last;
    acc  = v && !m_pend_v;
    good = (d >= 2);
    m_err = acc && !good;
    if (!m_on) begin
      if (acc && good) m_div = d;
      if (e) begin m_on = 1; m_stopping = 0; m_pos = 0; end
    end else begin
      last = (m_pos == m_div - 1);
      if (m_stopping) begin
        if (e) m_stopping = 0;
        else if (last) begin m_on = 0; m_stopping = 0; end
      end else if (!e) m_stopping = 1;
      if (last) begin
        m_pos = 0;
        if (acc && good) m_div = d;
        else if (m_pend_v) m_div = m_pend;
        m_pend_v = 0;
      end else begin
        m_pos = m_pos + 1;
        if (acc && good) begin m_pend_v = 1; m_pend = d; end
      end
    end
  endtask

  function automatic logic [VW-1:0] model_out();
    logic [CNT_W-1:0] dv;
    dv = CNT_W'(m_div);
    return {m_on && (m_pos < m_div / 2), m_on && (m_pos == m_div - 1), m_on,
            !m_pend_v, m_err, dv};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step(en, cfg_if.cfg_valid, int'(cfg_if.cfg_div));
        exp_q.push_back(model_out());
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [VW-1:0] act, exp_v;
    forever begin
      @(posedge clk_in);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {clk_out, tick, busy, cfg_if.cfg_ready, cfg_if.cfg_err, cur_div};
        n_tests++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_outputs cyc=%0d {clk_out,tick,busy,ready,err,div} got=%0b_%0b_%0b_%0b_%0b_%0d want=%0b_%0b_%0b_%0b_%0b_%0d",
                   cyc, act[VW-1], act[VW-2], act[VW-3], act[VW-4], act[VW-5], act[CNT_W-1:0],
                   exp_v[VW-1], exp_v[VW-2], exp_v[VW-3], exp_v[VW-4], exp_v[VW-5], exp_v[CNT_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp_v);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
    chk("rst_cfg_err", int'(cfg_if.cfg_err), 0);
    chk("rst_cur_div", int'(cur_div), DEF_DIV);
  endtask

  // Assert reset away from any clock edge and check outputs right away.
  task automatic reset_dut();
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    en = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    #1 check_reset_values();
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Called at a negedge; holds the request until it has transferred.
  task automatic send_cfg(input int d);
    bit done;
    done = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div = CNT_W'(d);
    for (int k = 0; k < 64 && !done; k++) begin
      if (cfg_if.cfg_ready) done = 1;
      @(negedge clk_in);
    end
    cfg_if.cfg_valid = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL cfg_timeout got=no_transfer want=transfer div=%0d", d);
    end
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      if (tick) seen = 1;
      else @(negedge clk_in);
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL tick_timeout got=no_tick want=tick");
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    bit xfer;
    rst_n = 1'b0;
    en = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div = '0;
    repeat (3) @(negedge clk_in);
    check_reset_values();
    rst_n = 1'b1;

    // defaults, period 7
    idle(2);
    en = 1'b1;
    idle(30);
    chk("busy_running", int'(busy), 1);
    en = 1'b0;
    idle(20);
    chk("busy_stopped", int'(busy), 0);

    // divisor 4 loaded while idle
    send_cfg(4);
    idle(2);
    chk("idle_load_div", int'(cur_div), 4);
    en = 1'b1;
    idle(17);

    // back to 7, then change to 10 mid-period
    send_cfg(7);
    idle(9);
    wait_tick();
    idle(3);
    send_cfg(10);
    chk("ready_low_pending", int'(cfg_if.cfg_ready), 0);
    idle(30);

    // rejected divisor, then a request in the tick cycle
    send_cfg(7);
    idle(12);
    send_cfg(1);
    chk("err_pulse", int'(cfg_if.cfg_err), 1);
    idle(3);
    send_cfg(0);
    idle(10);
    wait_tick();
    send_cfg(5);
    idle(12);

    // stop then resume before boundary, then full stop
    send_cfg(7);
    idle(9);
    wait_tick();
    idle(2);
    en = 1'b0;
    idle(3);
    en = 1'b1;
    idle(12);
    wait_tick();
    idle(2);
    en = 1'b0;
    idle(12);
    chk("stop_idle_clk", int'(clk_out), 0);

    // reset with a change pending
    en = 1'b1;
    idle(9);
    wait_tick();
    idle(3);
    send_cfg(12);
    reset_dut();
    idle(3);

    // randomized phase
    xfer = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk_in);
      if (xfer) cfg_if.cfg_valid = 1'b0;
      if (!cfg_if.cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = CNT_W'($urandom_range(0, 20));
      end
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 799) == 0) begin
        reset_dut();
        xfer = 0;
      end else begin
        xfer = cfg_if.cfg_valid && cfg_if.cfg_ready;
      end
    end

    cfg_if.cfg_valid = 1'b0;
    en = 1'b0;
    idle(30);
    chk("final_idle_busy", int'(busy), 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
